// File: rtl/alu_regfile_ctrl.sv
// Command sequencer and 8x8 register file feeding an external 8-bit ALU.
// Optional divide-by-zero trap enabled with the ALU_DIV0_TRAP_EN macro.
module alu_regfile_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [2:0]        cmd_rd,
  input  logic [2:0]        cmd_ra,
  input  logic [2:0]        cmd_rb,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_nowb,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_carry_in,
  output logic [4:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [3:0]        status_flags,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [1:0]        dbg_state
`ifdef ALU_DIV0_TRAP_EN
  ,
  output logic              div0_err
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid is held by its source until that edge.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept, capture;

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [2:0]        rd_q;
  logic              nowb_q;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              wb_en;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        capture   = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready = rst_n && (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;

  // r0 reads as zero regardless of storage contents.
  assign rd_a     = (cmd_ra == 3'd0)   ? '0 : rf[cmd_ra];
  assign rd_b     = (cmd_rb == 3'd0)   ? '0 : rf[cmd_rb];
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

`ifdef ALU_DIV0_TRAP_EN
  logic div0_hit;
  assign div0_hit = (alu_ctrl == 5'b00011) && (alu_b == '0);
  assign wb_en    = !nowb_q && (rd_q != 3'd0) && !div0_hit;
`else
  assign wb_en    = !nowb_q && (rd_q != 3'd0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      status_flags <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= '0;
      alu_carry_in <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      rd_q         <= '0;
      nowb_q       <= 1'b0;
    end else begin
      if (accept) begin
        alu_a        <= rd_a;
        alu_b        <= cmd_use_imm ? cmd_imm : rd_b;
        alu_ctrl     <= cmd_op;
        alu_carry_in <= status_flags[0];
        rd_q         <= cmd_rd;
        nowb_q       <= cmd_nowb;
      end
      if (capture) begin
        rsp_result   <= alu_result;
        rsp_flags    <= alu_flags;
        status_flags <= alu_flags;
        if (wb_en) rf[rd_q] <= alu_result;
      end
    end
  end

`ifdef ALU_DIV0_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                    div0_err <= 1'b0;
    else if (capture && div0_hit)  div0_err <= 1'b1;
  end
`endif

endmodule
